sram_dp_sync: RTL and testbench

- Parametrised true-dual-port synchronous SRAM for the example SoC; successor to the single-port behavioural SRAM.
- Two independent read/write ports (A, B) sharing one clock, each with per-byte write enables.
- Adds selectable read-during-write mode, a configurable read latency of 1 or 2 with a valid strobe, cross-port collision resolution and flagging, and an optional post-reset zero-fill sequencer.
- Intended for shared instruction/data RAM between a Hazard3 core and a DMA/debug master.

---
 rtl/sram_dp_sync_pkg.sv | 19 +
 rtl/sram_dp_clear_seq.sv | 51 +++++
 rtl/sram_dp_sync.sv | 122 ++++++++++++
 tb/tb_sram_dp_sync.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_dp_sync_pkg.sv
// Shared encodings for the dual-port SRAM: read-during-write modes,
// legal read latencies and the zero-fill sequencer states.
package sram_dp_sync_pkg;

  localparam int RDW_OLD   = 0;
  localparam int RDW_NEW   = 1;
  localparam int LAT_SHORT = 1;
  localparam int LAT_LONG  = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_e;

  function automatic bit is_two_stage(input int lat);
    return lat == LAT_LONG;
  endfunction

endpackage

// File: rtl/sram_dp_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word once, then idles.
// Its write request borrows port A's write path while init_busy is high.
module sram_dp_clear_seq
  import sram_dp_sync_pkg::*;
#(
  parameter int DEPTH          = 2048,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  clr_wen,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  logic                  busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          // Busy drops together with the write of the last word.
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = busy_reg;
  assign clr_wen   = (state_reg == ST_CLEAR);
  assign clr_addr  = cnt_reg;

endmodule

// File: rtl/sram_dp_sync.sv
// True dual-port synchronous SRAM with byte enables, selectable
// read-during-write, 1/2-cycle read latency and cross-port collision flag.
module sram_dp_sync
  import sram_dp_sync_pkg::*;
#(
  parameter int    WIDTH          = 32,
  parameter int    DEPTH          = 2048,
  parameter int    ADDR_WIDTH     = $clog2(DEPTH),
  parameter int    READ_LATENCY   = 1,
  parameter int    WRITE_FIRST    = 0,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string PRELOAD_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  a_en,
  input  logic [WIDTH/8-1:0]    a_wen,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wdata,
  output logic [WIDTH-1:0]      a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic [WIDTH/8-1:0]    b_wen,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]      b_wdata,
  output logic [WIDTH-1:0]      b_rdata,
  output logic                  b_rvalid,
  output logic                  collision
);

  localparam int                  NB        = WIDTH / 8;
  localparam bit                  TWO_STAGE = is_two_stage(READ_LATENCY);
  localparam bit                  MERGE_NEW = (WRITE_FIRST == RDW_NEW);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic                  clr_wen;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_dp_clear_seq #(
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_wen   (clr_wen),
    .clr_addr  (clr_addr)
  );

  logic a_acc, b_acc, a_in, b_in, a_wr, b_wr;
  assign a_acc = a_en & ~init_busy;
  assign b_acc = b_en & ~init_busy;
  assign a_in  = {1'b0, a_addr} < DEPTH_W;
  assign b_in  = {1'b0, b_addr} < DEPTH_W;
  assign a_wr  = a_acc & (|a_wen);
  assign b_wr  = b_acc & (|b_wen);

  // Port A's write path is shared with the zero-fill sequencer.
  logic [NB-1:0]         wa_be, wb_be;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [WIDTH-1:0]      wa_data;
  assign wa_be   = init_busy ? {NB{clr_wen}} : ((a_acc && a_in) ? a_wen : '0);
  assign wa_addr = init_busy ? clr_addr : a_addr;
  assign wa_data = init_busy ? '0 : a_wdata;
  assign wb_be   = (b_acc && b_in) ? b_wen : '0;

  // Port B is written after port A so it wins on a shared byte.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wa_be[i]) mem[wa_addr][i*8 +: 8] <= wa_data[i*8 +: 8];
      if (wb_be[i]) mem[b_addr][i*8 +: 8]  <= b_wdata[i*8 +: 8];
    end
  end

  logic [WIDTH-1:0] a_old, b_old, a_merge, b_merge;
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign a_merge[gi*8 +: 8] = (MERGE_NEW && a_wen[gi]) ? a_wdata[gi*8 +: 8] : a_old[gi*8 +: 8];
    assign b_merge[gi*8 +: 8] = (MERGE_NEW && b_wen[gi]) ? b_wdata[gi*8 +: 8] : b_old[gi*8 +: 8];
  end

  logic [WIDTH-1:0] a_rd1_reg, a_rd2_reg, b_rd1_reg, b_rd2_reg;
  logic             a_v1_reg, a_v2_reg, b_v1_reg, b_v2_reg;
  logic             collision_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rd1_reg     <= '0;
      a_rd2_reg     <= '0;
      b_rd1_reg     <= '0;
      b_rd2_reg     <= '0;
      a_v1_reg      <= 1'b0;
      a_v2_reg      <= 1'b0;
      b_v1_reg      <= 1'b0;
      b_v2_reg      <= 1'b0;
      collision_reg <= 1'b0;
    end else begin
      a_v1_reg <= a_acc;
      b_v1_reg <= b_acc;
      if (a_acc) a_rd1_reg <= a_in ? a_merge : '0;
      if (b_acc) b_rd1_reg <= b_in ? b_merge : '0;
      a_v2_reg <= a_v1_reg;
      b_v2_reg <= b_v1_reg;
      if (a_v1_reg) a_rd2_reg <= a_rd1_reg;
      if (b_v1_reg) b_rd2_reg <= b_rd1_reg;
      collision_reg <= a_acc && b_acc && (a_addr == b_addr) && (a_wr || b_wr);
    end
  end

  assign a_rdata   = TWO_STAGE ? a_rd2_reg : a_rd1_reg;
  assign a_rvalid  = TWO_STAGE ? a_v2_reg  : a_v1_reg;
  assign b_rdata   = TWO_STAGE ? b_rd2_reg : b_rd1_reg;
  assign b_rvalid  = TWO_STAGE ? b_v2_reg  : b_v1_reg;
  assign collision = collision_reg;

endmodule

// File: tb/tb_sram_dp_sync.sv
// Two instances (16 words/latency 1/new-data and 12 words/latency 2/old-data)
// driven with the same traffic and compared against a word-level model.
module tb_sram_dp_sync;

  localparam int W  = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_en [2];
  logic          b_en [2];
  logic [3:0]    a_wen [2];
  logic [3:0]    b_wen [2];
  logic [AW-1:0] a_addr [2];
  logic [AW-1:0] b_addr [2];
  logic [W-1:0]  a_wdata [2];
  logic [W-1:0]  b_wdata [2];
  logic [W-1:0]  a_rdata [2];
  logic [W-1:0]  b_rdata [2];
  logic          a_rvalid [2];
  logic          b_rvalid [2];
  logic          collision [2];
  logic          init_busy [2];

  sram_dp_sync #(
    .WIDTH(W), .DEPTH(16), .READ_LATENCY(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst(rst), .init_busy(init_busy[0]),
    .a_en(a_en[0]), .a_wen(a_wen[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
    .b_en(b_en[0]), .b_wen(b_wen[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
    .collision(collision[0])
  );

  sram_dp_sync #(
    .WIDTH(W), .DEPTH(12), .READ_LATENCY(2), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst(rst), .init_busy(init_busy[1]),
    .a_en(a_en[1]), .a_wen(a_wen[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
    .b_en(b_en[1]), .b_wen(b_wen[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
    .collision(collision[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int txn = 0;

  int depth_k [2];
  int lat_k [2];
  bit wf_k [2];

  // Reference model: memory image plus the previous cycle's read result
  logic [W-1:0] mm [2][16];
  bit           pv_a [2];
  bit           pv_b [2];
  logic [W-1:0] pd_a [2];
  logic [W-1:0] pd_b [2];
  logic [W-1:0] last_a [2];
  logic [W-1:0] last_b [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] apply(input logic [W-1:0] old, input logic [3:0] be,
                                          input logic [W-1:0] d);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pv_a[k] = 1'b0; pv_b[k] = 1'b0;
      pd_a[k] = '0;   pd_b[k] = '0;
      last_a[k] = '0; last_b[k] = '0;
    end
  endtask

  task automatic cycle(input logic ae, input logic [3:0] aw, input logic [AW-1:0] aa,
                       input logic [W-1:0] ad, input logic be, input logic [3:0] bw,
                       input logic [AW-1:0] ba, input logic [W-1:0] bd);
    bit           cv_a [2];
    bit           cv_b [2];
    bit           col [2];
    logic [W-1:0] cd_a [2];
    logic [W-1:0] cd_b [2];
    bit           in_a, in_b, dv;
    logic [W-1:0] old_a, old_b, dd;
    for (int k = 0; k < 2; k++) begin
      a_en[k] = ae; a_wen[k] = aw; a_addr[k] = aa; a_wdata[k] = ad;
      b_en[k] = be; b_wen[k] = bw; b_addr[k] = ba; b_wdata[k] = bd;
      in_a  = int'(aa) < depth_k[k];
      in_b  = int'(ba) < depth_k[k];
      old_a = in_a ? mm[k][aa] : '0;
      old_b = in_b ? mm[k][ba] : '0;
      cv_a[k] = ae;
      cv_b[k] = be;
      cd_a[k] = !in_a ? '0 : (wf_k[k] ? apply(old_a, aw, ad) : old_a);
      cd_b[k] = !in_b ? '0 : (wf_k[k] ? apply(old_b, bw, bd) : old_b);
      col[k]  = ae && be && (aa == ba) && (aw != 4'h0 || bw != 4'h0);
      if (ae && in_a) mm[k][aa] = apply(mm[k][aa], aw, ad);
      if (be && in_b) mm[k][ba] = apply(mm[k][ba], bw, bd);
    end
    $display("txn %0d A en=%0d wen=%h addr=%0d wdata=%h | B en=%0d wen=%h addr=%0d wdata=%h",
             txn, ae, aw, aa, ad, be, bw, ba, bd);
    txn++;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      dv = (lat_k[k] == 1) ? cv_a[k] : pv_a[k];
      dd = (lat_k[k] == 1) ? cd_a[k] : pd_a[k];
      if (dv) last_a[k] = dd;
      chk($sformatf("dut%0d a_rvalid", k), 32'(a_rvalid[k]), 32'(dv));
      chk($sformatf("dut%0d a_rdata", k), a_rdata[k], last_a[k]);
      dv = (lat_k[k] == 1) ? cv_b[k] : pv_b[k];
      dd = (lat_k[k] == 1) ? cd_b[k] : pd_b[k];
      if (dv) last_b[k] = dd;
      chk($sformatf("dut%0d b_rvalid", k), 32'(b_rvalid[k]), 32'(dv));
      chk($sformatf("dut%0d b_rdata", k), b_rdata[k], last_b[k]);
      chk($sformatf("dut%0d collision", k), 32'(collision[k]), 32'(col[k]));
      chk($sformatf("dut%0d init_busy", k), 32'(init_busy[k]), 32'd0);
      pv_a[k] = cv_a[k]; pd_a[k] = cd_a[k];
      pv_b[k] = cv_b[k]; pd_b[k] = cd_b[k];
    end
  endtask

  // Asserted mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d rst a_rvalid", k), 32'(a_rvalid[k]), 32'd0);
      chk($sformatf("dut%0d rst b_rvalid", k), 32'(b_rvalid[k]), 32'd0);
      chk($sformatf("dut%0d rst a_rdata", k), a_rdata[k], 32'd0);
      chk($sformatf("dut%0d rst b_rdata", k), b_rdata[k], 32'd0);
      chk($sformatf("dut%0d rst collision", k), 32'(collision[k]), 32'd0);
      chk($sformatf("dut%0d rst init_busy", k), 32'(init_busy[k]), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Requests a read of word 15 on port A until busy is seen low; none may be served.
  task automatic run_clear(input int stop_at);
    int cnt [2];
    bit done [2];
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 1; done[k] = 1'b0;
      a_en[k] = 1'b1; a_wen[k] = 4'h0; a_addr[k] = 4'd15; a_wdata[k] = '0;
      b_en[k] = 1'b0; b_wen[k] = 4'h0; b_addr[k] = '0;    b_wdata[k] = '0;
    end
    for (int t = 1; t <= 40 && !(done[0] && done[1]); t++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d busy a_rvalid", k), 32'(a_rvalid[k]), 32'd0);
        if (!done[k]) begin
          if (init_busy[k]) cnt[k]++;
          else begin
            done[k] = 1'b1;
            a_en[k] = 1'b0;
          end
        end
      end
      if (t == stop_at) begin
        a_en[0] = 1'b0;
        a_en[1] = 1'b0;
        return;
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d busy cycles", k), 32'(cnt[k]), 32'(depth_k[k]));
      for (int i = 0; i < 16; i++) mm[k][i] = '0;
    end
  endtask

  initial begin
    logic          ae, be;
    logic [3:0]    aw, bw;
    logic [AW-1:0] aa, ba;
    depth_k = '{16, 12};
    lat_k   = '{1, 2};
    wf_k    = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      a_en[k] = 1'b0; a_wen[k] = 4'h0; a_addr[k] = '0; a_wdata[k] = '0;
      b_en[k] = 1'b0; b_wen[k] = 4'h0; b_addr[k] = '0; b_wdata[k] = '0;
    end
    model_reset();
    @(posedge clk);
    #1;

    do_reset();
    run_clear(8);
    do_reset();
    run_clear(0);

    // Every word must read back as zero after the fill
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 4'h0, AW'(i), $urandom, 1'b1, 4'h0, AW'(15 - i), $urandom);

    cycle(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    chk("basic a_rdata", a_rdata[0], 32'hDEADBEEF);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    chk("basic b_rdata", b_rdata[0], 32'hDEADBEEF);

    cycle(1'b1, 4'hF, 4'd7, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'b0101, 4'd7, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0);
    chk("rdw new-data", a_rdata[0], 32'h11BB33DD);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    chk("rdw old-data", a_rdata[1], 32'h11223344);

    cycle(1'b1, 4'b0011, 4'd9, 32'h000000FF, 1'b1, 4'b0110, 4'd9, 32'hFFFF0000);
    chk("ww collision", 32'(collision[0]), 32'd1);
    cycle(1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    chk("ww merged word", a_rdata[0], 32'h00FF00FF);
    chk("ww collision pulse", 32'(collision[0]), 32'd0);

    cycle(1'b1, 4'hF, 4'd3, 32'h12345678, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'hF, 4'd3, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    chk("rw reader old", b_rdata[0], 32'h12345678);
    chk("rw collision", 32'(collision[0]), 32'd1);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    chk("rw later read", b_rdata[0], 32'h0);

    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd1, 32'hA5A5_0001);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd2, 32'hA5A5_0002);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'h0, AW'(i), 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b1, 4'h0, 4'd13, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    cycle(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    chk("oob rvalid", 32'(a_rvalid[1]), 32'd1);
    chk("oob rdata", a_rdata[1], 32'h0);

    for (int n = 0; n < 300; n++) begin
      ae = 1'($urandom_range(0, 1));
      be = 1'($urandom_range(0, 1));
      aw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      aa = AW'($urandom_range(0, 15));
      ba = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, 15));
      cycle(ae, aw, aa, $urandom, be, bw, ba, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
